// File: rtl/io_word_deserializer_pkg.sv
// Types shared by the word deserializer and its output FIFO.
// Holds the receive FSM state enum, the buffered word struct and widths.
package io_rx_p;

    localparam int DATA_WIDTH     = 8;
    localparam int BEATS_PER_WORD = 4;
    localparam int RX_WORD_WIDTH  = DATA_WIDTH * BEATS_PER_WORD;

    typedef enum logic {
        IDLE,
        COLLECT
    } rx_state_e;

    typedef struct packed {
        logic [RX_WORD_WIDTH-1:0] data;
        logic                     last;
    } rx_word_s;

endpackage

// File: rtl/sys_structs.sv
// Shared system-level types.
// clk_domain bundles the clock, a global stall enable and a sync reset.
package sys_structs;

    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_domain;

endpackage

// File: rtl/io_word_deserializer_fifo.sv
// rx_word_fifo: show-ahead sync FIFO of rx_word_s with registered level.
// Ports: sys_dom_i/rst_n, wr_en_i/wr_word_i, rd_en_i, rd_word_o, level_o, full_o.
module rx_word_fifo
    import sys_structs::*;
    import io_rx_p::*;
#(
    parameter int Depth = 4
) (
    input  clk_domain              sys_dom_i,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  rx_word_s               wr_word_i,
    input  logic                   rd_en_i,
    output rx_word_s               rd_word_o,
    output logic [$clog2(Depth):0] level_o,
    output logic                   full_o
);

    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;

    rx_word_s          mem_q [Depth];
    rx_word_s          mem_d [Depth];
    logic     [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic     [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic     [LW-1:0] level_q, level_d;
    logic              do_wr, do_rd;
    logic              unused_sync_rst;

    assign unused_sync_rst = sys_dom_i.sync_rst;

    assign full_o    = (level_q == LW'(Depth));
    assign level_o   = level_q;
    assign rd_word_o = mem_q[rd_ptr_q];

    // A write into a full FIFO is accepted only when a read frees a slot.
    assign do_rd = rd_en_i && (level_q != '0);
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_word_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge sys_dom_i.clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (sys_dom_i.clk_en) begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/io_word_deserializer.sv
// io_word_deserializer: assembles ticked beats into words, tags frame end, FIFO out.
// Ports: sys_dom_i/rst_n, rx_* inputs, word_* valid/ready out, level, sticky errors.
module io_word_deserializer
    import sys_structs::*;
    import io_rx_p::*;
#(
    parameter int Data_Width     = DATA_WIDTH,
    parameter int Beats_Per_Word = BEATS_PER_WORD,
    parameter int Fifo_Depth     = 4
) (
    input  clk_domain                            sys_dom_i,
    input  logic                                 rst_n,
    input  logic                                 rx_enable_i,
    input  logic                                 tick_input_i,
    input  logic [Data_Width-1:0]                rx_data_i,
    input  logic                                 short_pause_i,
    input  logic                                 long_pause_i,
    output logic                                 word_valid_o,
    input  logic                                 word_ready_i,
    output logic [Data_Width*Beats_Per_Word-1:0] word_data_o,
    output logic                                 word_last_o,
    output logic [$clog2(Fifo_Depth):0]          fifo_level_o,
    output logic                                 overflow_err_o,
    output logic                                 align_err_o,
    input  logic                                 err_clear_i
);

    localparam int CW = $clog2(Beats_Per_Word);
    localparam int WW = Data_Width * Beats_Per_Word;
    localparam logic [CW-1:0] LAST_BEAT = CW'(Beats_Per_Word - 1);

    rx_state_e state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [Beats_Per_Word-1:0][Data_Width-1:0] beats_q, beats_d;
    logic [WW-1:0] stg_q, stg_d;
    logic stg_valid_q, stg_valid_d;
    logic align_q, align_d;
    logic ovf_q, ovf_d;

    logic     push, pop, full, align_set, ovf_set;
    rx_word_s push_word, head_word;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        beats_d     = beats_q;
        stg_d       = stg_q;
        stg_valid_d = stg_valid_q;
        push        = 1'b0;
        push_word   = '0;
        align_set   = 1'b0;
        if (!rx_enable_i) begin
            state_d     = IDLE;
            beat_cnt_d  = '0;
            stg_valid_d = 1'b0;
        end else begin
            // A staged word always sits at beat_cnt 0, and a word needs
            // at least two beats, so the tick push and a completion
            // never collide in one cycle.
            if (tick_input_i) begin
                state_d = COLLECT;
                if (stg_valid_q) begin
                    push           = 1'b1;
                    push_word.data = stg_q;
                    push_word.last = 1'b0;
                    stg_valid_d    = 1'b0;
                end
                beats_d[beat_cnt_q] = rx_data_i;
                if (beat_cnt_q == LAST_BEAT) begin
                    beat_cnt_d  = '0;
                    stg_d       = beats_d;
                    stg_valid_d = 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            // Pauses see the state already updated by this cycle's tick.
            if (short_pause_i || long_pause_i) begin
                if (beat_cnt_d != '0) begin
                    align_set  = 1'b1;
                    beat_cnt_d = '0;
                end
                if (stg_valid_d) begin
                    push           = 1'b1;
                    push_word.data = stg_d;
                    push_word.last = long_pause_i;
                    stg_valid_d    = 1'b0;
                end
                if (long_pause_i) begin
                    state_d = IDLE;
                end
            end
        end
    end

    assign pop     = word_valid_o && word_ready_i;
    assign ovf_set = push && full && !pop;

    // A set in the same cycle as a clear keeps the error visible.
    always_comb begin
        align_d = align_q;
        ovf_d   = ovf_q;
        if (err_clear_i) begin
            align_d = 1'b0;
            ovf_d   = 1'b0;
        end
        if (align_set) begin
            align_d = 1'b1;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge sys_dom_i.clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            beats_q     <= '0;
            stg_q       <= '0;
            stg_valid_q <= 1'b0;
            align_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (sys_dom_i.clk_en) begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            beats_q     <= beats_d;
            stg_q       <= stg_d;
            stg_valid_q <= stg_valid_d;
            align_q     <= align_d;
            ovf_q       <= ovf_d;
        end
    end

    rx_word_fifo #(
        .Depth (Fifo_Depth)
    ) u_fifo (
        .sys_dom_i (sys_dom_i),
        .rst_n     (rst_n),
        .wr_en_i   (push),
        .wr_word_i (push_word),
        .rd_en_i   (pop),
        .rd_word_o (head_word),
        .level_o   (fifo_level_o),
        .full_o    (full)
    );

    assign word_valid_o   = (fifo_level_o != '0);
    assign word_data_o    = head_word.data;
    assign word_last_o    = head_word.last;
    assign overflow_err_o = ovf_q;
    assign align_err_o    = align_q;

endmodule

// File: tb/tb_io_word_deserializer.sv
// Scoreboard bench for io_word_deserializer.
// Expected words are queued as stimulus is driven and popped on FIFO reads.
module tb_io_word_deserializer;
    import sys_structs::*;
    import io_rx_p::*;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst_n = 1'b0;
    logic        rx_enable = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        sp = 1'b0;
    logic        lp = 1'b0;
    logic        ready = 1'b0;
    logic        err_clear = 1'b0;
    logic        valid;
    logic [31:0] wdata;
    logic        wlast;
    logic [2:0]  level;
    logic        ovf;
    logic        align;
    clk_domain   sys_dom;

    int n_cmp = 0;
    int n_err = 0;
    rx_word_s exp_q [$];

    assign sys_dom = '{clk: clk, clk_en: clk_en, sync_rst: 1'b0};

    always #5 clk = ~clk;

    io_word_deserializer dut (
        .sys_dom_i      (sys_dom),
        .rst_n          (rst_n),
        .rx_enable_i    (rx_enable),
        .tick_input_i   (tick),
        .rx_data_i      (rx_data),
        .short_pause_i  (sp),
        .long_pause_i   (lp),
        .word_valid_o   (valid),
        .word_ready_i   (ready),
        .word_data_o    (wdata),
        .word_last_o    (wlast),
        .fifo_level_o   (level),
        .overflow_err_o (ovf),
        .align_err_o    (align),
        .err_clear_i    (err_clear)
    );

    task automatic do_tick(input logic [7:0] d, input logic s, input logic l);
        tick = 1'b1; rx_data = d; sp = s; lp = l;
        @(negedge clk);
        tick = 1'b0; sp = 1'b0; lp = 1'b0;
    endtask

    task automatic do_pause(input logic s, input logic l);
        sp = s; lp = l;
        @(negedge clk);
        sp = 1'b0; lp = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_word(output logic [31:0] d, output logic l, output logic ok);
        ok = 1'b0; d = '0; l = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid) begin
                d = wdata; l = wlast; ok = 1'b1;
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (wdata !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", wdata); end
        n_cmp++; if (wlast !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", wlast); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_cmp++; if (align !== 1'b0) begin n_err++; $display("FAIL reset_align got %b want 0", align); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic_frame();
        logic [31:0] d; logic l, ok; rx_word_s e;
        for (int i = 1; i <= 4; i++) do_tick(8'(8'h11 * i), 1'b0, 1'b0);
        exp_q.push_back('{data: 32'h44332211, last: 1'b0});
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_staged_valid got %b want 0", valid); end
        do_tick(8'h55, 1'b0, 1'b0);
        n_cmp++; if (valid !== 1'b1 || level !== 3'd1) begin
            n_err++; $display("FAIL basic_push_latency valid %b level %0d want 1/1", valid, level); end
        for (int i = 6; i <= 8; i++) do_tick(8'(8'h11 * i), 1'b0, 1'b0);
        exp_q.push_back('{data: 32'h88776655, last: 1'b1});
        do_pause(1'b0, 1'b1);
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL basic_level got %0d want 2", level); end
        while (exp_q.size() > 0) begin
            pop_word(d, l, ok); e = exp_q.pop_front();
            n_cmp++; if (!ok || d !== e.data || l !== e.last) begin
                n_err++; $display("FAIL basic_word got %h/%b ok %b want %h/%b", d, l, ok, e.data, e.last); end
        end
        n_cmp++; if (ovf !== 1'b0 || align !== 1'b0) begin
            n_err++; $display("FAIL basic_errs ovf %b align %b want 0/0", ovf, align); end
    endtask

    task automatic test_align();
        do_tick(8'h01, 1'b0, 1'b0);
        do_tick(8'h02, 1'b0, 1'b0);
        do_pause(1'b1, 1'b0);
        n_cmp++; if (align !== 1'b1) begin n_err++; $display("FAIL align_set got %b want 1", align); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL align_noword level %0d want 0", level); end
        err_clear = 1'b1; idle(1); err_clear = 1'b0;
        n_cmp++; if (align !== 1'b0) begin n_err++; $display("FAIL align_clear got %b want 0", align); end
        do_tick(8'h03, 1'b0, 1'b0);
        err_clear = 1'b1;
        do_pause(1'b1, 1'b0);
        err_clear = 1'b0;
        n_cmp++; if (align !== 1'b1) begin n_err++; $display("FAIL align_set_wins got %b want 1", align); end
        err_clear = 1'b1; idle(1); err_clear = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] d, w; logic l, ok; rx_word_s e;
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            w = '0;
            for (int b = 0; b < 4; b++) begin
                w[b*8 +: 8] = 8'(k * 16 + b + 1);
                do_tick(8'(k * 16 + b + 1), 1'b0, 1'b0);
            end
            if (k < 4) exp_q.push_back('{data: w, last: 1'b0});
        end
        do_pause(1'b0, 1'b1);
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d want 4", level); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf); end
        while (exp_q.size() > 0) begin
            pop_word(d, l, ok); e = exp_q.pop_front();
            n_cmp++; if (!ok || d !== e.data || l !== e.last) begin
                n_err++; $display("FAIL ovf_word got %h/%b ok %b want %h/%b", d, l, ok, e.data, e.last); end
        end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL ovf_drained level %0d want 0", level); end
        err_clear = 1'b1; idle(1); err_clear = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", ovf); end
    endtask

    task automatic test_tick_long_pause();
        logic [31:0] d; logic l, ok; rx_word_s e;
        do_pause(1'b0, 1'b1);
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL lp_empty level %0d want 0", level); end
        do_tick(8'hC1, 1'b0, 1'b0);
        do_tick(8'hC2, 1'b0, 1'b0);
        do_tick(8'hC3, 1'b0, 1'b0);
        exp_q.push_back('{data: 32'hC4C3C2C1, last: 1'b1});
        do_tick(8'hC4, 1'b0, 1'b1);
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL lp_coincide level %0d want 1", level); end
        for (int b = 0; b < 4; b++) do_tick(8'(8'hD0 + b), 1'b0, 1'b0);
        exp_q.push_back('{data: 32'hD3D2D1D0, last: 1'b1});
        do_pause(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            pop_word(d, l, ok); e = exp_q.pop_front();
            n_cmp++; if (!ok || d !== e.data || l !== e.last) begin
                n_err++; $display("FAIL lp_word got %h/%b ok %b want %h/%b", d, l, ok, e.data, e.last); end
        end
        n_cmp++; if (align !== 1'b0) begin n_err++; $display("FAIL lp_align got %b want 0", align); end
    endtask

    task automatic test_enable_drop();
        logic [31:0] d; logic l, ok; rx_word_s e;
        for (int b = 0; b < 4; b++) do_tick(8'(8'hE0 + b), 1'b0, 1'b0);
        exp_q.push_back('{data: 32'hE3E2E1E0, last: 1'b0});
        do_pause(1'b1, 1'b0);
        for (int b = 0; b < 4; b++) do_tick(8'(8'hF0 + b), 1'b0, 1'b0);
        rx_enable = 1'b0;
        do_tick(8'h99, 1'b0, 1'b0);
        do_pause(1'b0, 1'b1);
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL en_drop level %0d want 1", level); end
        pop_word(d, l, ok); e = exp_q.pop_front();
        n_cmp++; if (!ok || d !== e.data || l !== e.last) begin
            n_err++; $display("FAIL en_retained got %h/%b ok %b want %h/%b", d, l, ok, e.data, e.last); end
        rx_enable = 1'b1;
        for (int b = 0; b < 3; b++) do_tick(8'(8'hA0 + b), 1'b0, 1'b0);
        rx_enable = 1'b0; idle(1); rx_enable = 1'b1;
        for (int b = 0; b < 4; b++) do_tick(8'(8'hB0 + b), 1'b0, 1'b0);
        exp_q.push_back('{data: 32'hB3B2B1B0, last: 1'b1});
        do_pause(1'b0, 1'b1);
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL en_clean level %0d want 1", level); end
        while (exp_q.size() > 0) begin
            pop_word(d, l, ok); e = exp_q.pop_front();
            n_cmp++; if (!ok || d !== e.data || l !== e.last) begin
                n_err++; $display("FAIL en_word got %h/%b ok %b want %h/%b", d, l, ok, e.data, e.last); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d; logic l, ok; rx_word_s e;
        for (int b = 0; b < 4; b++) do_tick(8'(8'h60 + b), 1'b0, 1'b0);
        exp_q.push_back('{data: 32'h63626160, last: 1'b0});
        do_pause(1'b1, 1'b0);
        do_tick(8'hA1, 1'b0, 1'b0);
        do_tick(8'hA2, 1'b0, 1'b0);
        clk_en = 1'b0; ready = 1'b1;
        for (int i = 0; i < 5; i++) do_tick(8'(8'h5A + i), 1'b0, 1'b0);
        n_cmp++; if (level !== 3'd1 || valid !== 1'b1 || wdata !== 32'h63626160) begin
            n_err++; $display("FAIL stall_hold level %0d valid %b data %h want 1/1/63626160", level, valid, wdata); end
        clk_en = 1'b1; ready = 1'b0;
        do_tick(8'hA3, 1'b0, 1'b0);
        do_tick(8'hA4, 1'b0, 1'b0);
        exp_q.push_back('{data: 32'hA4A3A2A1, last: 1'b1});
        do_pause(1'b0, 1'b1);
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL stall_level got %0d want 2", level); end
        while (exp_q.size() > 0) begin
            pop_word(d, l, ok); e = exp_q.pop_front();
            n_cmp++; if (!ok || d !== e.data || l !== e.last) begin
                n_err++; $display("FAIL stall_word got %h/%b ok %b want %h/%b", d, l, ok, e.data, e.last); end
        end
        n_cmp++; if (align !== 1'b0) begin n_err++; $display("FAIL stall_align got %b want 0", align); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_align();
        test_overflow();
        test_tick_long_pause();
        test_enable_drop();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
